// File: rtl/oai_pkg.sv
// Shared definitions for the OAI gate vector checker: FSM encodings,
// the golden gate function and the settle-time limit.
package oai_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int HOLD_MAX = 15;

  // Expected gate output for input vector {a,b,c} = idx
  function automatic logic oai_exp(input logic [2:0] idx);
    return ~((idx[2] | idx[1]) & idx[0]);
  endfunction

endpackage

// File: rtl/oai_vec_checker_hold_timer.sv
// Settle timer for one vector: counts up while enabled and flags the
// last hold cycle (count == HOLD-1). Clear wins over enable.
module hold_timer
  import oai_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // Out-of-range settings are clamped into 1..HOLD_MAX so the terminal
  // compare always hits inside the 4-bit count range.
  localparam int HOLD_EFF = (HOLD < 1) ? 1 : ((HOLD > HOLD_MAX) ? HOLD_MAX : HOLD);
  localparam logic [3:0] TC_VAL = 4'(HOLD_EFF - 1);

  logic [3:0] cnt;

  // Hold counter: cleared on reset or request, otherwise counts when enabled
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 4'd0;
    end else if (en) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/oai_vec_checker.sv
// Stimulus/compare stage for the external OAI gate: walks all eight
// {a,b,c} vectors, lets each settle, checks e against the golden value
// and reports error count, last failing vector and pass/done flags.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, gate inputs parked at 000
// S_HOLD  | driving idx onto a/b/c while the gate settles
// S_CHECK | compare e against golden, then advance or finish
// S_DONE  | results held, a/b/c parked at 111, start restarts
module oai_vec_checker
  import oai_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       e,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] last_fail
);

  state_t     state;
  logic [2:0] idx;
  logic       hold_tc;
  logic       timer_clr;
  logic       timer_en;
  logic       launch;
  logic       mismatch;

  assign launch    = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign timer_en  = (state == S_HOLD);
  assign timer_clr = launch || ((state == S_HOLD) && hold_tc);
  assign mismatch  = (e != oai_exp(idx));

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .en  (timer_en),
    .tc  (hold_tc)
  );

  // Sweep FSM with registered gate drive, status flags and results
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= 3'd0;
      err_cnt   <= 4'd0;
      last_fail <= 3'd0;
      {a, b, c} <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_HOLD;
            idx       <= 3'd0;
            err_cnt   <= 4'd0;
            last_fail <= 3'd0;
            {a, b, c} <= 3'b000;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        S_HOLD: begin
          if (hold_tc) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            err_cnt   <= err_cnt + 4'd1;
            last_fail <= idx;
          end
          if (idx == 3'd7) begin
            state     <= S_DONE;
            {a, b, c} <= 3'b111;
            busy      <= 1'b0;
            done      <= 1'b1;
            // Final vector's result folds in here since err_cnt updates on this same edge
            pass      <= (err_cnt == 4'd0) && !mismatch;
          end else begin
            state     <= S_HOLD;
            idx       <= idx + 3'd1;
            {a, b, c} <= idx + 3'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oai_vec_checker.sv
// Randomized self-checking bench for oai_vec_checker. Two instances
// (HOLD=2 and HOLD=1) each drive a behavioural gate with optional faults.
module tb_oai_vec_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2, start1, start2;
  logic a1, b1, c1, busy1, done1, pass1, e1;
  logic a2, b2, c2, busy2, done2, pass2, e2;
  logic [3:0] err1, err2;
  logic [2:0] lf1, lf2;

  int         fault_mode;
  logic [7:0] fault_mask;
  int         checks;
  int         failures;

  // Gate truth: output is 0 exactly when c is set and at least one of a/b is set,
  // i.e. odd vector numbers from 3 upward.
  function automatic logic golden(input int v);
    return !((v % 2 == 1) && (v >= 2));
  endfunction

  // 0 good gate, 1 stuck-at-0, 2 stuck-at-1, 3 good gate with per-vector flips
  function automatic logic fault_e(input int mode, input logic [7:0] mask, input int v);
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return golden(v) ^ mask[v];
      default: return golden(v);
    endcase
  endfunction

  assign e1 = fault_e(fault_mode, fault_mask, int'({a1, b1, c1}));
  assign e2 = fault_e(fault_mode, fault_mask, int'({a2, b2, c2}));

  oai_vec_checker #(.HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .e(e1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .last_fail(lf1)
  );

  oai_vec_checker #(.HOLD(2)) u_dut2 (
    .clk(clk), .rst(rst2), .start(start2), .e(e2),
    .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .last_fail(lf2)
  );

  // Observation word: {busy, done, pass, a, b, c, err_cnt, last_fail}
  function automatic logic [12:0] get_obs(input int h);
    if (h == 1) return {busy1, done1, pass1, a1, b1, c1, err1, lf1};
    else        return {busy2, done2, pass2, a2, b2, c2, err2, lf2};
  endfunction

  task automatic drive_start(input int h, input logic v);
    if (h == 1) start1 = v;
    else        start2 = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one sweep and compare every cycle against the model up to DONE.
  task automatic run_sweep(input string name, input int h, input int mode,
                           input logic [7:0] mask, input bit keep_start,
                           input bit late_pulse);
    int per;
    int total;
    int err;
    int lf;
    logic [12:0] exp;
    per   = h + 1;
    total = 8 * per;
    fault_mode = mode;
    fault_mask = mask;
    drive_start(h, 1'b1);
    tick();
    if (!keep_start) drive_start(h, 1'b0);
    for (int k = 0; k <= total; k++) begin
      err = 0;
      lf  = 0;
      for (int j = 0; j < 8; j++) begin
        if (((j + 1) * per <= k) && (fault_e(mode, mask, j) != golden(j))) begin
          err++;
          lf = j;
        end
      end
      if (k < total) exp = {1'b1, 1'b0, 1'b0, 3'(k / per), 4'(err), 3'(lf)};
      else           exp = {1'b0, 1'b1, (err == 0), 3'd7, 4'(err), 3'(lf)};
      checks++;
      if (get_obs(h) !== exp) begin
        failures++;
        $display("FAIL %s h=%0d cycle=%0d obs=%013b exp=%013b", name, h, k, get_obs(h), exp);
      end
      if (k < total) begin
        if (late_pulse && k == total - 1) drive_start(h, 1'b1);
        tick();
        if (late_pulse && k == total - 1) drive_start(h, 1'b0);
      end
    end
  endtask

  task automatic test_reset;
    rst1 = 1'b1; rst2 = 1'b1;
    start1 = 1'b1; start2 = 1'b1;
    fault_mode = 0; fault_mask = 8'h00;
    tick(); tick();
    for (int h = 1; h <= 2; h++) begin
      checks++;
      if (get_obs(h) !== 13'd0) begin
        failures++;
        $display("FAIL reset_with_start h=%0d obs=%013b exp=0", h, get_obs(h));
      end
    end
    rst1 = 1'b0; rst2 = 1'b0;
    start1 = 1'b0; start2 = 1'b0;
    tick();
    for (int h = 1; h <= 2; h++) begin
      checks++;
      if (get_obs(h) !== 13'd0) begin
        failures++;
        $display("FAIL reset_idle h=%0d obs=%013b exp=0", h, get_obs(h));
      end
    end
  endtask

  task automatic test_good_gate;
    run_sweep("good_h2", 2, 0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_stuck;
    run_sweep("stuck0_h2", 2, 1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (err2 !== 4'd5 || lf2 !== 3'd6 || pass2 !== 1'b0) begin
      failures++;
      $display("FAIL stuck0_result err=%0d lf=%0d pass=%0b exp err=5 lf=6 pass=0", err2, lf2, pass2);
    end
    run_sweep("stuck1_h2", 2, 2, 8'h00, 1'b0, 1'b0);
    checks++;
    if (err2 !== 4'd3 || lf2 !== 3'd7 || pass2 !== 1'b0) begin
      failures++;
      $display("FAIL stuck1_result err=%0d lf=%0d pass=%0b exp err=3 lf=7 pass=0", err2, lf2, pass2);
    end
  endtask

  task automatic test_random_faults;
    logic [7:0] m;
    for (int i = 0; i < 6; i++) begin
      m = 8'($urandom);
      run_sweep("random_fault", 1 + (i % 2), 3, m, 1'b0, 1'b0);
    end
  endtask

  task automatic test_mid_reset;
    fault_mode = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (12) tick();
    checks++;
    if ({busy2, a2, b2, c2} !== 4'b1100) begin
      failures++;
      $display("FAIL mid_reset_pre busy_abc=%04b exp=1100", {busy2, a2, b2, c2});
    end
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    checks++;
    if (get_obs(2) !== 13'd0) begin
      failures++;
      $display("FAIL mid_reset_clear obs=%013b exp=0", get_obs(2));
    end
    tick();
    checks++;
    if (get_obs(2) !== 13'd0) begin
      failures++;
      $display("FAIL mid_reset_stay_idle obs=%013b exp=0", get_obs(2));
    end
    run_sweep("after_mid_reset", 2, 0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_start_at_done_entry;
    run_sweep("late_start", 2, 2, 8'h00, 1'b0, 1'b1);
    tick();
    checks++;
    if ({busy2, done2, err2} !== {1'b0, 1'b1, 4'd3}) begin
      failures++;
      $display("FAIL late_start_ignored busy=%0b done=%0b err=%0d exp busy=0 done=1 err=3",
               busy2, done2, err2);
    end
  endtask

  task automatic test_back_to_back;
    run_sweep("start_held", 2, 1, 8'h00, 1'b1, 1'b0);
    tick();
    checks++;
    if (get_obs(2) !== {1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 3'd0}) begin
      failures++;
      $display("FAIL start_held_restart obs=%013b exp=1000000000000", get_obs(2));
    end
    start2 = 1'b0;
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
  endtask

  task automatic test_hold1;
    run_sweep("good_h1", 1, 0, 8'h00, 1'b0, 1'b0);
    run_sweep("stuck1_h1", 1, 2, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_good_gate();
    test_stuck();
    test_random_faults();
    test_mid_reset();
    test_start_at_done_entry();
    test_back_to_back();
    test_hold1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
